// File: rtl/exe_muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package exe_muldiv_pkg;

    localparam int unsigned MD_XLEN = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned REG_AW  = 5;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M      = 7'b0000001;

    typedef enum logic [2:0] {
        INST_MUL    = 3'd0,
        INST_MULH   = 3'd1,
        INST_MULHSU = 3'd2,
        INST_MULHU  = 3'd3,
        INST_DIV    = 3'd4,
        INST_DIVU   = 3'd5,
        INST_REM    = 3'd6,
        INST_REMU   = 3'd7
    } m_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_inst_t;

endpackage

// File: rtl/exe_muldiv_if.sv
// ID/EXE operand bus, pipeline control and result beat of the muldiv unit.
interface exe_muldiv_if #(
    parameter int unsigned XLEN = exe_muldiv_pkg::MD_XLEN
) ();
    import exe_muldiv_pkg::*;

    logic [INST_W-1:0] inst_i;
    logic [XLEN-1:0]   op1_i;
    logic [XLEN-1:0]   op2_i;
    logic [REG_AW-1:0] reg_waddr_i;
    logic              flush_i;
    logic              hold_i;
    logic              stall_req_o;
    logic              result_valid_o;
    logic [XLEN-1:0]   result_o;
    logic [REG_AW-1:0] reg_waddr_o;
    logic              busy_o;

    modport master (
        output inst_i, op1_i, op2_i, reg_waddr_i, flush_i, hold_i,
        input  stall_req_o, result_valid_o, result_o, reg_waddr_o, busy_o
    );

    modport slave (
        input  inst_i, op1_i, op2_i, reg_waddr_i, flush_i, hold_i,
        output stall_req_o, result_valid_o, result_o, reg_waddr_o, busy_o
    );

endinterface

// File: rtl/exe_div_iter.sv
// Iterative unsigned restoring divider; DIV_UNROLL quotient bits per cycle.
// The first step is taken in the start cycle, so done_o pulses after
// XLEN/DIV_UNROLL - 1 further cycles.
module exe_div_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int unsigned STEPS = XLEN / DIV_UNROLL;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;

    logic [XLEN-1:0]  src_rem;
    logic [XLEN-1:0]  src_quo;
    logic [XLEN-1:0]  src_dvs;
    logic [XLEN-1:0]  rem_d;
    logic [XLEN-1:0]  quo_d;
    logic [XLEN:0]    trial;

    // DIV_UNROLL shift-subtract steps; a new start seeds from the inputs
    always_comb begin
        src_rem = start_i ? '0         : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        src_dvs = start_i ? divisor_i  : dvs_q;
        rem_d   = src_rem;
        quo_d   = src_quo;
        trial   = '0;
        for (int unsigned k = 0; k < DIV_UNROLL; k++) begin
            trial = {rem_d, quo_d[XLEN-1]};
            quo_d = {quo_d[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, src_dvs}) begin
                trial    = trial - {1'b0, src_dvs};
                quo_d[0] = 1'b1;
            end
            rem_d = trial[XLEN-1:0];
        end
    end

    // Iteration state; done_q is a one-cycle pulse after the last step
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= divisor_i;
            cnt_q  <= CNT_W'(STEPS - 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            busy_q <= (cnt_q != CNT_W'(1));
            done_q <= (cnt_q == CNT_W'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// RV32M multiply/divide unit of the execute stage: stalls the front end
// while an op runs, then presents a single result beat.
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = MD_XLEN,
    parameter int unsigned DIV_UNROLL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    exe_muldiv_if.slave bus
);

    localparam int unsigned   PW      = 2 * XLEN;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   op2_q;
    logic [2:0]        funct3_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   result_q;
    logic [REG_AW-1:0] waddr_q;

    // Issue-time decode
    r_inst_t inst_c;
    logic    unused_inst;
    logic    is_m_c;
    logic    launch_c;
    logic    stall_c;
    assign inst_c      = r_inst_t'(bus.inst_i);
    assign unused_inst = ^{inst_c.rs2, inst_c.rs1, inst_c.rd};
    assign is_m_c      = (inst_c.opcode == INST_TYPE_R_M) && (inst_c.funct7 == FUNCT7_M);
    assign launch_c    = (state_q == ST_IDLE) && is_m_c && !bus.flush_i;
    assign stall_c     = launch_c
                       || (!bus.flush_i && ((state_q == ST_MUL) || (state_q == ST_DIV)));

    // Divide special cases resolve at issue; the rest feed magnitudes to the divider
    logic            div_signed_c;
    logic            div_zero_c;
    logic            div_ovf_c;
    logic            special_c;
    logic [XLEN-1:0] special_res_c;
    logic [XLEN-1:0] abs1_c;
    logic [XLEN-1:0] abs2_c;
    logic            div_start_c;
    assign div_signed_c  = !inst_c.funct3[0];
    assign div_zero_c    = (bus.op2_i == '0);
    assign div_ovf_c     = div_signed_c && (bus.op1_i == INT_MIN) && (bus.op2_i == '1);
    assign special_c     = div_zero_c || div_ovf_c;
    assign special_res_c = inst_c.funct3[1] ? (div_zero_c ? bus.op1_i : '0)
                                            : (div_zero_c ? '1 : INT_MIN);
    assign abs1_c        = (div_signed_c && bus.op1_i[XLEN-1]) ? XLEN'(-bus.op1_i) : bus.op1_i;
    assign abs2_c        = (div_signed_c && bus.op2_i[XLEN-1]) ? XLEN'(-bus.op2_i) : bus.op2_i;
    assign div_start_c   = launch_c && inst_c.funct3[2] && !special_c;

    // Full-width product of the latched operands, sign-extended per funct3
    logic            mul_sa_c;
    logic            mul_sb_c;
    logic [PW-1:0]   mul_a_c;
    logic [PW-1:0]   mul_b_c;
    logic [PW-1:0]   prod_c;
    logic [XLEN-1:0] mul_res_c;
    assign mul_sa_c  = (funct3_q == INST_MULH) || (funct3_q == INST_MULHSU);
    assign mul_sb_c  = (funct3_q == INST_MULH);
    assign mul_a_c   = {{XLEN{mul_sa_c & op1_q[XLEN-1]}}, op1_q};
    assign mul_b_c   = {{XLEN{mul_sb_c & op2_q[XLEN-1]}}, op2_q};
    assign prod_c    = mul_a_c * mul_b_c;
    assign mul_res_c = (funct3_q == INST_MUL) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];

    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;

    exe_div_iter #(
        .XLEN       (XLEN),
        .DIV_UNROLL (DIV_UNROLL)
    ) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start_c),
        .abort_i     (bus.flush_i),
        .dividend_i  (abs1_c),
        .divisor_i   (abs2_c),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Sign fix-up: quotient takes sign(op1)^sign(op2), remainder takes sign(op1)
    logic            neg_quo_c;
    logic            neg_rem_c;
    logic [XLEN-1:0] div_res_c;
    assign neg_quo_c = !funct3_q[0] && (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
    assign neg_rem_c = !funct3_q[0] && op1_q[XLEN-1];
    assign div_res_c = funct3_q[1] ? (neg_rem_c ? XLEN'(-div_rem) : div_rem)
                                   : (neg_quo_c ? XLEN'(-div_quo) : div_quo);

    // Control FSM; result and rd only update on entry to DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
            waddr_q  <= '0;
        end else if (bus.flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch_c) begin
                        op1_q    <= bus.op1_i;
                        op2_q    <= bus.op2_i;
                        funct3_q <= inst_c.funct3;
                        rd_q     <= bus.reg_waddr_i;
                        if (!inst_c.funct3[2]) begin
                            state_q <= ST_MUL;
                        end else if (special_c) begin
                            result_q <= special_res_c;
                            waddr_q  <= bus.reg_waddr_i;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    result_q <= mul_res_c;
                    waddr_q  <= rd_q;
                    state_q  <= ST_DONE;
                end
                ST_DIV: begin
                    if (div_done) begin
                        result_q <= div_res_c;
                        waddr_q  <= rd_q;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.hold_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall_req_o    = !rst_i && stall_c;
    assign bus.result_valid_o = (state_q == ST_DONE) && !bus.flush_i;
    assign bus.result_o       = result_q;
    assign bus.reg_waddr_o    = waddr_q;
    assign bus.busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv against an arithmetic RV32M model.
module tb_exe_muldiv;
    import exe_muldiv_pkg::*;

    localparam logic [31:0] NOP_ADD = 32'h0020_8033;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   op_id    = 0;

    always #5 clk = ~clk;

    exe_muldiv_if #(.XLEN(32)) bus ();

    exe_muldiv #(.XLEN(32), .DIV_UNROLL(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3 < 3'd4) return 2;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one M-op, follow it to its result beat, optionally hold it, then retire
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold_cycles);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        int          stalls;
        bit          got;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        op_id++;
        bus.inst_i      = {FUNCT7_M, 5'd2, 5'd1, f3, rd, INST_TYPE_R_M};
        bus.op1_i       = a;
        bus.op2_i       = b;
        bus.reg_waddr_i = rd;
        lat    = 0;
        stalls = 0;
        got    = 1'b0;
        #1;
        while (!got && lat < 100) begin
            if (bus.result_valid_o) begin
                got = 1'b1;
            end else begin
                lat++;
                if (bus.stall_req_o) stalls++;
                @(posedge clk);
                #1;
                bus.op1_i = $urandom;
                bus.op2_i = $urandom;
                @(negedge clk);
                #1;
            end
        end
        check($sformatf("op%0d f3=%0d valid_seen", op_id, f3), 32'(got), 32'd1);
        check($sformatf("op%0d f3=%0d latency", op_id, f3), 32'(lat), 32'(exp_lat));
        check($sformatf("op%0d f3=%0d stall_cycles", op_id, f3), 32'(stalls), 32'(exp_lat));
        check($sformatf("op%0d f3=%0d result a=%h b=%h", op_id, f3, a, b), bus.result_o, exp_res);
        check($sformatf("op%0d waddr", op_id), 32'(bus.reg_waddr_o), 32'(rd));
        check($sformatf("op%0d stall_in_done", op_id), 32'(bus.stall_req_o), 32'd0);
        for (int i = 0; i < hold_cycles; i++) begin
            bus.hold_i = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk);
            #1;
            check($sformatf("op%0d hold%0d valid", op_id, i), 32'(bus.result_valid_o), 32'd1);
            check($sformatf("op%0d hold%0d result", op_id, i), bus.result_o, exp_res);
        end
        bus.hold_i = 1'b0;
        @(posedge clk);
        #1;
        bus.inst_i      = NOP_ADD;
        bus.reg_waddr_i = 5'd0;
        @(negedge clk);
        #1;
        check($sformatf("op%0d idle_valid", op_id), 32'(bus.result_valid_o), 32'd0);
        check($sformatf("op%0d idle_busy", op_id), 32'(bus.busy_o), 32'd0);
        check($sformatf("op%0d idle_stall", op_id), 32'(bus.stall_req_o), 32'd0);
    endtask

    initial begin
        bit          seen;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        rst             = 1'b1;
        bus.inst_i      = NOP_ADD;
        bus.op1_i       = '0;
        bus.op2_i       = '0;
        bus.reg_waddr_i = '0;
        bus.flush_i     = 1'b0;
        bus.hold_i      = 1'b0;
        #1;
        check("rst valid", 32'(bus.result_valid_o), 32'd0);
        check("rst stall", 32'(bus.stall_req_o), 32'd0);
        check("rst busy", 32'(bus.busy_o), 32'd0);
        check("rst result", bus.result_o, 32'd0);
        check("rst waddr", 32'(bus.reg_waddr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Directed operations
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
        check("mul 7*-3 literal", bus.result_o, 32'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
        check("mulhu literal", bus.result_o, 32'hFFFF_FFFE);
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5, 0);
        check("div -20/3 literal", bus.result_o, 32'hFFFF_FFFA);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 0);
        check("rem -20/3 literal", bus.result_o, 32'hFFFF_FFFE);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 0);
        run_op(3'd4, 32'd5, 32'd0, 5'd8, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd9, 0);
        run_op(3'd4, INT_MIN, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(3'd6, INT_MIN, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd12, 4);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd0, 5'd13, 2);

        // Flush in the middle of a divide: no result beat may escape
        bus.inst_i      = {FUNCT7_M, 5'd2, 5'd1, 3'd4, 5'd14, INST_TYPE_R_M};
        bus.op1_i       = 32'd1000;
        bus.op2_i       = 32'd7;
        bus.reg_waddr_i = 5'd14;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        #1;
        bus.flush_i = 1'b1;
        #1;
        check("flush stall same cycle", 32'(bus.stall_req_o), 32'd0);
        check("flush valid same cycle", 32'(bus.result_valid_o), 32'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.inst_i  = NOP_ADD;
        @(negedge clk);
        #1;
        check("flush stall next", 32'(bus.stall_req_o), 32'd0);
        check("flush busy next", 32'(bus.busy_o), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.result_valid_o) seen = 1'b1;
        end
        check("flush no valid", 32'(seen), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd15, 0);
        check("mul 3*4 literal", bus.result_o, 32'd12);

        // Asynchronous reset in the middle of a divide
        bus.inst_i      = {FUNCT7_M, 5'd2, 5'd1, 3'd5, 5'd16, INST_TYPE_R_M};
        bus.op1_i       = 32'h1234_5678;
        bus.op2_i       = 32'd9;
        bus.reg_waddr_i = 5'd16;
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst valid", 32'(bus.result_valid_o), 32'd0);
        check("arst stall", 32'(bus.stall_req_o), 32'd0);
        check("arst busy", 32'(bus.busy_o), 32'd0);
        check("arst result", bus.result_o, 32'd0);
        check("arst waddr", 32'(bus.reg_waddr_o), 32'd0);
        bus.inst_i = NOP_ADD;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bus.stall_req_o || bus.busy_o) seen = 1'b1;
        end
        check("add never stalls", 32'(seen), 32'd0);

        // Randomised operations biased toward boundary operands
        for (int n = 0; n < 24; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = INT_MIN;
                1:       a = 32'($urandom_range(0, 200)) - 32'd100;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(0, 40)) - 32'd20;
                default: b = $urandom;
            endcase
            run_op(f3, a, b, 5'($urandom_range(1, 31)), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
